// File: rtl/rbm_pkg.sv
// Shared types and helpers for the RBM visible-layer reconstruction engine:
// controller states, accumulator sizing, piecewise-linear sigmoid and LFSR taps.
package rbm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAC  = 3'd1,
    POST = 3'd2,
    DONE = 3'd3
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as a mask over state bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int acc_width(input int n, input int nh);
    return n + $clog2(nh) + 1;
  endfunction

  // Slope set by the shift, centred on 128, clamped to the 9-bit range 0..256
  function automatic logic [8:0] sigmoid_pla(input int s, input int shift);
    int t;
    t = (s >>> shift) + 128;
    if (t < 0) return 9'd0;
    if (t > 256) return 9'd256;
    return 9'(t);
  endfunction

endpackage

// File: rtl/rbm_lfsr16.sv
// 16-bit Fibonacci LFSR providing the random threshold for stochastic sampling.
module rbm_lfsr16
  import rbm_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else if (step) begin
      state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/rbm_visible_recon_engine.sv
// RBM visible-layer reconstruction: per neuron, LANES-wide MAC over the hidden vector,
// bias add, PWL sigmoid, then a threshold or LFSR-stochastic decision.
module rbm_visible_recon_engine
  import rbm_pkg::*;
#(
  parameter int          NV        = 16,
  parameter int          NH        = 16,
  parameter int          N         = 8,
  parameter int          LANES     = 4,
  parameter int          SIG_SHIFT = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [NH-1:0]         h_in,
  input  logic                  w_wr_en,
  input  logic [$clog2(NV)-1:0] w_wr_row,
  input  logic [$clog2(NH)-1:0] w_wr_col,
  input  logic [N-1:0]          w_wr_data,
  input  logic                  b_wr_en,
  input  logic [$clog2(NV)-1:0] b_wr_addr,
  input  logic [N-1:0]          b_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [NV-1:0]         v_out,
  output logic [2:0]            state_display
);

  localparam int ACC_W = acc_width(N, NH);
  localparam int RW    = $clog2(NV);
  localparam int CW    = $clog2(NH);
  localparam int IDX_W = $clog2(NV * NH);

  generate
    if ((NH % LANES) != 0) begin : g_lane_check
      $error("NH must be a multiple of LANES");
    end
    if (LFSR_SEED == 16'h0000) begin : g_seed_check
      $error("LFSR_SEED must be non-zero");
    end
  endgenerate

  state_t                   state;
  logic [RW-1:0]            row;
  logic [CW-1:0]            col;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  lane_sum;
  logic signed [ACC_W-1:0]  s_sum;
  logic [8:0]               p_val;
  logic                     sample;
  logic [NH-1:0]            h_reg;
  logic                     mode_reg;
  logic [NV-1:0]            v_shadow;
  logic [15:0]              lfsr;
  logic                     unused_lfsr_hi;

  logic signed [N-1:0] w_mem [NV*NH];
  logic signed [N-1:0] b_mem [NV];

  // Coefficient memories are not reset and only accept writes while idle
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (w_wr_en) w_mem[IDX_W'(int'(w_wr_row) * NH + int'(w_wr_col))] <= w_wr_data;
      if (b_wr_en) b_mem[b_wr_addr] <= b_wr_data;
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      if (h_reg[int'(col) + k]) begin
        lane_sum = lane_sum + ACC_W'(w_mem[IDX_W'(int'(row) * NH + int'(col) + k)]);
      end
    end
  end

  always_comb begin
    s_sum  = acc + ACC_W'(b_mem[row]);
    p_val  = sigmoid_pla(int'(s_sum), SIG_SHIFT);
    sample = mode_reg ? (p_val > {1'b0, lfsr[7:0]}) : !s_sum[ACC_W-1];
  end

  rbm_lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .step (state == POST),
    .state(lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      v_out         <= '0;
      state_display <= IDLE;
      row           <= '0;
      col           <= '0;
      acc           <= '0;
      h_reg         <= '0;
      mode_reg      <= 1'b0;
      v_shadow      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            h_reg         <= h_in;
            mode_reg      <= mode;
            acc           <= '0;
            row           <= '0;
            col           <= '0;
            state         <= MAC;
            busy          <= 1'b1;
            state_display <= MAC;
          end
        end
        MAC: begin
          acc <= acc + lane_sum;
          col <= col + CW'(LANES);
          if (col == CW'(NH - LANES)) begin
            state         <= POST;
            state_display <= POST;
          end
        end
        POST: begin
          v_shadow[row] <= sample;
          acc           <= '0;
          if (row == RW'(NV - 1)) begin
            state         <= DONE;
            state_display <= DONE;
          end else begin
            row           <= row + 1'b1;
            col           <= '0;
            state         <= MAC;
            state_display <= MAC;
          end
        end
        DONE: begin
          v_out         <= v_shadow;
          done          <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
          state_display <= IDLE;
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          state_display <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rbm_visible_recon_engine.sv
// Directed, table-driven bench for rbm_visible_recon_engine with hand-computed results
// and a small reference LFSR for the stochastic vector.
module tb_rbm_visible_recon_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [15:0] h_in;
  logic        w_wr_en;
  logic [3:0]  w_wr_row;
  logic [3:0]  w_wr_col;
  logic [7:0]  w_wr_data;
  logic        b_wr_en;
  logic [3:0]  b_wr_addr;
  logic [7:0]  b_wr_data;
  logic        busy;
  logic        done;
  logic [15:0] v_out;
  logic [2:0]  state_display;

  int checks = 0;
  int passed = 0;
  logic [15:0] lfsr_model;

  typedef struct {
    int          w_kind;
    logic [7:0]  w_val;
    logic [7:0]  b_val;
    logic [15:0] h;
    logic        m;
    logic        use_model;
    logic [15:0] expect_v;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  rbm_visible_recon_engine dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .h_in         (h_in),
    .w_wr_en      (w_wr_en),
    .w_wr_row     (w_wr_row),
    .w_wr_col     (w_wr_col),
    .w_wr_data    (w_wr_data),
    .b_wr_en      (b_wr_en),
    .b_wr_addr    (b_wr_addr),
    .b_wr_data    (b_wr_data),
    .busy         (busy),
    .done         (done),
    .v_out        (v_out),
    .state_display(state_display)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference sampling for 16 POST cycles at a fixed probability
  task automatic advanceModel(input logic [8:0] p, output logic [15:0] bits);
    for (int i = 0; i < 16; i++) begin
      bits[i]    = (p > {1'b0, lfsr_model[7:0]});
      lfsr_model = {lfsr_model[14:0],
                    lfsr_model[15] ^ lfsr_model[13] ^ lfsr_model[12] ^ lfsr_model[10]};
    end
  endtask

  task automatic loadAll(input int kind, input logic [7:0] wv, input logic [7:0] bv);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        w_wr_en   = 1'b1;
        w_wr_row  = 4'(r);
        w_wr_col  = 4'(c);
        w_wr_data = (kind == 1 && (c % 2) == 1) ? 8'(8'd0 - wv) : wv;
        b_wr_en   = (c == 0);
        b_wr_addr = 4'(r);
        b_wr_data = bv;
      end
    end
    @(negedge clk);
    w_wr_en = 1'b0;
    b_wr_en = 1'b0;
  endtask

  task automatic writeOne(input logic is_bias, input logic [3:0] r, input logic [3:0] c,
                          input logic [7:0] d);
    @(negedge clk);
    if (is_bias) begin
      b_wr_en = 1'b1; b_wr_addr = r; b_wr_data = d;
    end else begin
      w_wr_en = 1'b1; w_wr_row = r; w_wr_col = c; w_wr_data = d;
    end
    @(negedge clk);
    w_wr_en = 1'b0;
    b_wr_en = 1'b0;
  endtask

  // Starts a run and follows it to done; optional mid-run disturbance or write with start
  task automatic applyStimulus(input logic [15:0] h, input logic m, input logic disturb,
                               input logic wr_with_start, output int lat,
                               output logic [15:0] res, output int done_cnt);
    @(negedge clk);
    h_in  = h;
    mode  = m;
    start = 1'b1;
    if (wr_with_start) begin
      w_wr_en = 1'b1; w_wr_row = 4'd0; w_wr_col = 4'd0; w_wr_data = 8'h80;
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    w_wr_en  = 1'b0;
    lat      = -1;
    done_cnt = 0;
    res      = '0;
    for (int n = 1; n <= 120; n++) begin
      @(posedge clk);
      #1;
      if (disturb && n == 20) begin
        start = 1'b1; h_in = 16'h0000;
        w_wr_en = 1'b1; w_wr_row = 4'd0; w_wr_col = 4'd0; w_wr_data = 8'h80;
      end
      if (disturb && n == 21) begin
        start = 1'b0; w_wr_en = 1'b0;
      end
      if (n == 1) checkOutput("display_mac", 32'(state_display), 32'd1);
      if (n == 4) checkOutput("display_post", 32'(state_display), 32'd2);
      if (n == 80) begin
        checkOutput("display_done", 32'(state_display), 32'd3);
        checkOutput("busy_in_done", 32'(busy), 32'd1);
      end
      if (done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = n;
          res = v_out;
        end
      end
      if (lat > 0 && n >= lat + 5) break;
    end
    checkOutput("busy_after_run", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int          lat;
    int          dcnt;
    logic [15:0] res;
    logic [15:0] exp_v;

    vecs[0] = '{0, 8'h01, 8'h00, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF};
    vecs[1] = '{0, 8'hFF, 8'h00, 16'hFFFF, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{1, 8'h01, 8'h00, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF};
    vecs[3] = '{1, 8'h01, 8'hFF, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{0, 8'h7F, 8'h7F, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF};
    vecs[5] = '{0, 8'h80, 8'h80, 16'hFFFF, 1'b1, 1'b0, 16'h0000};
    vecs[6] = '{0, 8'h03, 8'hF7, 16'h0007, 1'b0, 1'b0, 16'hFFFF};
    vecs[7] = '{0, 8'h02, 8'hDF, 16'h000F, 1'b0, 1'b0, 16'h0000};
    vecs[8] = '{0, 8'h01, 8'hFE, 16'h8001, 1'b0, 1'b0, 16'hFFFF};
    vecs[9] = '{0, 8'h00, 8'h00, 16'hFFFF, 1'b1, 1'b1, 16'h0000};

    reset = 1'b1; start = 1'b0; mode = 1'b0; h_in = '0;
    w_wr_en = 1'b0; w_wr_row = '0; w_wr_col = '0; w_wr_data = '0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    lfsr_model = 16'hACE1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_v_out", 32'(v_out), 32'd0);
    checkOutput("reset_display", 32'(state_display), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      loadAll(vecs[i].w_kind, vecs[i].w_val, vecs[i].b_val);
      applyStimulus(vecs[i].h, vecs[i].m, 1'b0, 1'b0, lat, res, dcnt);
      advanceModel(9'd128, exp_v);
      if (!vecs[i].use_model) exp_v = vecs[i].expect_v;
      checkOutput($sformatf("vec%0d_v_out", i), 32'(res), 32'(exp_v));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd81);
      checkOutput($sformatf("vec%0d_done_pulses", i), 32'(dcnt), 32'd1);
    end

    // Bias on neuron 3 lifts s from -16 to exactly 0
    loadAll(0, 8'hFF, 8'h00);
    writeOne(1'b1, 4'd3, 4'd0, 8'h10);
    applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b0, lat, res, dcnt);
    advanceModel(9'd128, exp_v);
    checkOutput("bias3_v_out", 32'(res), 32'h0008);

    // Write on the start cycle is used by that run
    loadAll(0, 8'h01, 8'h00);
    applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b1, lat, res, dcnt);
    advanceModel(9'd128, exp_v);
    checkOutput("wr_with_start_v_out", 32'(res), 32'hFFFE);
    writeOne(1'b0, 4'd0, 4'd0, 8'h01);

    // Start and weight write mid-run are both ignored
    applyStimulus(16'hFFFF, 1'b0, 1'b1, 1'b0, lat, res, dcnt);
    advanceModel(9'd128, exp_v);
    checkOutput("midrun_v_out", 32'(res), 32'hFFFF);
    checkOutput("midrun_latency", 32'(lat), 32'd81);
    checkOutput("midrun_done_pulses", 32'(dcnt), 32'd1);
    applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b0, lat, res, dcnt);
    advanceModel(9'd128, exp_v);
    checkOutput("midrun_write_dropped", 32'(res), 32'hFFFF);

    // Reset in the middle of a run
    @(negedge clk);
    h_in = 16'hFFFF; mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_display", 32'(state_display), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_v_out", 32'(v_out), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    lfsr_model = 16'hACE1;
    applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b0, lat, res, dcnt);
    advanceModel(9'd128, exp_v);
    checkOutput("after_reset_v_out", 32'(res), 32'hFFFF);
    checkOutput("after_reset_latency", 32'(lat), 32'd81);

    // Stochastic run after reset: LFSR sequence restarts from the seed
    loadAll(0, 8'h00, 8'h00);
    applyStimulus(16'hFFFF, 1'b1, 1'b0, 1'b0, lat, res, dcnt);
    advanceModel(9'd128, exp_v);
    checkOutput("stoch_after_reset_v_out", 32'(res), 32'(exp_v));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
